// File: rtl/decoder3_8_pulse_pkg.sv
// Shared definitions for the pulsed 3:8 decoder.
//  - Default parameter values (code width, pulse length, gap length, counter width)
//  - FSM state encoding used by the top level
package decoder3_8_pulse_pkg;

  localparam int DEF_IN_W      = 3;
  localparam int DEF_PULSE_LEN = 4;
  localparam int DEF_GAP_LEN   = 1;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder3_8_pulse_dec_onehot.sv
// dec_onehot: purely combinational binary -> one-hot decode.
//  code   in  IN_W       binary index
//  onehot out 2**IN_W    exactly one bit set, at position code
module dec_onehot #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      code,
  output logic [2**IN_W-1:0]   onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/decoder3_8_pulse.sv
// decoder3_8_pulse: accepts a binary code over valid/ready and drives the
// matching one-hot line high for PULSE_LEN cycles, then idles GAP_LEN
// cycles before accepting the next code.
//
// Ports:
//  clk       rising-edge clock
//  rst_n     asynchronous active-low reset
//  en        1 = new codes may be accepted; 0 = in_ready held low
//  abort     synchronous cancel of a pulse/gap in progress
//  in_valid  in_code is valid this cycle
//  in_code   binary code to decode
//  in_ready  block can accept a code this cycle
//  out       registered one-hot output, zero when not pulsing
//  busy      high while in PULSE or GAP
//  done      one-cycle strobe after a pulse completes normally
//
// Handshake: a code is taken on a rising edge where in_valid & in_ready.
// in_ready depends only on registered state plus en/abort/rst_n, never on
// in_valid. While in_ready is low the source must hold its code; nothing is
// latched until the transfer happens.
module decoder3_8_pulse
  import decoder3_8_pulse_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int GAP_LEN   = DEF_GAP_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_code,
  output logic                  in_ready,
  output logic [2**IN_W-1:0]    out,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_W = 2**IN_W;

  // Counter reload values; the counter counts down to zero inclusive, so a
  // load of LEN-1 gives LEN cycles in the state.
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   decoded;
  logic               accept;

  dec_onehot #(.IN_W(IN_W)) u_dec (
    .code   (in_code),
    .onehot (decoded)
  );

  // rst_n is folded in so in_ready is low for the whole reset window.
  assign in_ready = rst_n & en & ~abort & (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;

  assign out  = out_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;

    // abort wins over both a new accept and the normal end-of-pulse done.
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      out_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_PULSE;
            cnt_d   = PULSE_LOAD;
            out_d   = decoded;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            out_d  = '0;
            done_d = 1'b1;
            if (GAP_LEN > 0) begin
              state_d = ST_GAP;
              cnt_d   = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          out_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder3_8_pulse.sv
// Bench for decoder3_8_pulse. Two instances share the stimulus: one with
// GAP_LEN=1 and one with GAP_LEN=0. The reference model tracks, per
// instance, only whether a transaction is live, its code, and how many
// cycles have elapsed since it was accepted; every output is derived from
// that age with plain arithmetic.
module tb_decoder3_8_pulse;

  localparam int P    = 4;
  localparam int G_A  = 1;
  localparam int G_B  = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;

  logic       ready_a, busy_a, done_a;
  logic [7:0] out_a;
  logic       ready_b, busy_b, done_b;
  logic [7:0] out_b;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  decoder3_8_pulse #(.IN_W(3), .PULSE_LEN(P), .GAP_LEN(G_A), .CNT_W(8)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .abort    (abort),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (ready_a),
    .out      (out_a),
    .busy     (busy_a),
    .done     (done_a)
  );

  decoder3_8_pulse #(.IN_W(3), .PULSE_LEN(P), .GAP_LEN(G_B), .CNT_W(8)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .abort    (abort),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (ready_b),
    .out      (out_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  // ---------------- reference model ----------------
  bit act[2];
  int age[2];
  int code_m[2];
  int gap[2];
  int last_acc[2];
  int cyc = 0;
  bit hold_mode = 1'b0;
  bit acc_a_seen;

  int tests  = 0;
  int failed = 0;

  function automatic logic [7:0] exp_out(input int d);
    logic [7:0] one;
    one = 8'h01;
    if (act[d] && age[d] >= 1 && age[d] <= P) return one << code_m[d];
    return 8'h00;
  endfunction

  function automatic logic exp_done(input int d);
    return act[d] && (age[d] == P + 1);
  endfunction

  function automatic logic exp_busy(input int d);
    return act[d] && (age[d] <= P + gap[d]);
  endfunction

  function automatic logic exp_ready(input int d);
    return rst_n && en && !abort && !exp_busy(d);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      string n;
      n = (d == 0) ? "a" : "b";
      check({n, ".out"},      32'(d ? out_b   : out_a),   32'(exp_out(d)));
      check({n, ".done"},     32'(d ? done_b  : done_a),  32'(exp_done(d)));
      check({n, ".busy"},     32'(d ? busy_b  : busy_a),  32'(exp_busy(d)));
      check({n, ".in_ready"}, 32'(d ? ready_b : ready_a), 32'(exp_ready(d)));
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, predict/observe acceptance,
  // advance through the rising edge, check at the next falling edge.
  task automatic step(input bit e, input bit a, input bit v, input int c);
    bit acc[2];
    bit obs;
    logic [31:0] cv;
    cv       = 32'(c);
    en       = e;
    abort    = a;
    in_valid = v;
    in_code  = cv[2:0];
    #1;
    acc_a_seen = 1'b0;
    for (int d = 0; d < 2; d++) begin
      acc[d] = v && exp_ready(d);
      obs    = in_valid && (d ? ready_b : ready_a);
      check((d == 0) ? "a.accept" : "b.accept", 32'(obs), 32'(acc[d]));
      if (obs) begin
        if (hold_mode && last_acc[d] >= 0)
          check((d == 0) ? "a.spacing" : "b.spacing", 32'(cyc - last_acc[d]), 32'(P + gap[d] + 1));
        last_acc[d] = cyc;
        if (d == 0) acc_a_seen = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (a) act[d] = 1'b0;
      else if (act[d]) age[d]++;
      if (acc[d]) begin
        act[d]    = 1'b1;
        age[d]    = 1;
        code_m[d] = c;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    int budget;
    gap[0] = G_A;
    gap[1] = G_B;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; age[d] = 0; code_m[d] = 0; last_acc[d] = -1;
    end

    // Reset: outputs quiet and in_ready low while held, ready right after.
    en = 1'b1;
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();
    check("a.ready_after_reset", 32'(ready_a), 32'd1);

    // Decode sweep with in_valid held; code advances when instance a takes it.
    hold_mode = 1'b1;
    last_acc[0] = -1; last_acc[1] = -1;
    c = 0;
    budget = 0;
    while (c < 8 && budget < 200) begin
      step(1'b1, 1'b0, 1'b1, c);
      if (acc_a_seen) c++;
      budget++;
    end
    check("sweep_codes_accepted", 32'(c), 32'd8);
    hold_mode = 1'b0;
    idle(8);

    // Abort in the second pulse cycle of code 5.
    step(1'b1, 1'b0, 1'b1, 5);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    idle(4);

    // en dropped after accepting code 3; held in_valid must not be taken.
    step(1'b1, 1'b0, 1'b1, 3);
    repeat (10) step(1'b0, 1'b0, 1'b1, 3);
    step(1'b1, 1'b0, 1'b1, 3);
    idle(8);

    // in_valid held with code 6: back-to-back repeats.
    hold_mode = 1'b1;
    last_acc[0] = -1; last_acc[1] = -1;
    repeat (16) step(1'b1, 1'b0, 1'b1, 6);
    hold_mode = 1'b0;
    idle(8);

    // Async reset during the second pulse cycle of code 7.
    step(1'b1, 1'b0, 1'b1, 7);
    step(1'b1, 1'b0, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    act[0] = 1'b0;
    act[1] = 1'b0;
    check_all();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Randomized traffic.
    repeat (400) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0, int'($urandom_range(0, 7)));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
